// File: rtl/decode_pkg.sv
// Shared definitions for the decode queue: entry layout, default lane counts
// and the mask helpers used for lane compaction and prefix accept.
package decode_pkg;

  localparam int DECODE_DATA_WIDTH = 126;

  localparam int DEF_ENQ_W = 2;
  localparam int DEF_DEQ_W = 2;
  localparam int DEF_DEPTH = 8;

  // Field offsets inside one decoded entry, LSB first.
  localparam int PC_LSB         = 0;
  localparam int PC_W           = 32;
  localparam int INST_LSB       = 32;
  localparam int INST_W         = 32;
  localparam int INST_VALID_BIT = 64;
  localparam int ALUOP_LSB      = 65;
  localparam int ALUOP_W        = 8;
  localparam int ALUSEL_LSB     = 73;
  localparam int ALUSEL_W       = 3;
  localparam int IMM_LSB        = 76;
  localparam int IMM_W          = 32;
  localparam int REG1_READ_BIT  = 108;
  localparam int REG1_ADDR_LSB  = 109;
  localparam int REG2_READ_BIT  = 114;
  localparam int REG2_ADDR_LSB  = 115;
  localparam int WREG_BIT       = 120;
  localparam int WD_LSB         = 121;
  localparam int REG_ADDR_W     = 5;

  function automatic int popcount(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

  // Number of consecutive ones starting at bit 0, looking at the low w bits.
  function automatic int lead_ones(input logic [31:0] v, input int w);
    int n;
    bit run;
    n = 0;
    run = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (run && (i < w) && v[i]) n++;
      else run = 1'b0;
    end
    return n;
  endfunction

endpackage

// File: rtl/decode_queue_ram.sv
// Entry storage for decode_queue: DEPTH x DATA_W register array with ENQ_W
// write ports and DEQ_W asynchronous read ports. Contents are not reset.
module decode_queue_ram
  import decode_pkg::*;
#(
  parameter int DATA_W = DECODE_DATA_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ENQ_W  = DEF_ENQ_W,
  parameter int DEQ_W  = DEF_DEQ_W,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic [ENQ_W-1:0]               wr_en,
  input  logic [ENQ_W-1:0][AW-1:0]       wr_addr,
  input  logic [ENQ_W-1:0][DATA_W-1:0]   wr_data,
  input  logic [DEQ_W-1:0][AW-1:0]       rd_addr,
  output logic [DEQ_W-1:0][DATA_W-1:0]   rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write addresses of enabled lanes are always distinct.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_W; i++) begin
      if (wr_en[i]) mem[wr_addr[i]] <= wr_data[i];
    end
  end

  always_comb begin
    for (int i = 0; i < DEQ_W; i++) rd_data[i] = mem[rd_addr[i]];
  end

endmodule

// File: rtl/decode_queue.sv
// Multi-lane decode-to-dispatch queue with sparse-mask compaction, prefix
// dequeue, flush and registered enqueue credit. Optional same-cycle bypass
// when empty is enabled by defining DECODE_QUEUE_BYPASS_EN.
module decode_queue
  import decode_pkg::*;
#(
  parameter int DATA_W = DECODE_DATA_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ENQ_W  = DEF_ENQ_W,
  parameter int DEQ_W  = DEF_DEQ_W
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [ENQ_W-1:0]               enq_valid,
  input  logic [ENQ_W-1:0][DATA_W-1:0]   enq_data,
  output logic                           get_data_req,
  output logic [DEQ_W-1:0]               deq_valid,
  output logic [DEQ_W-1:0][DATA_W-1:0]   deq_data,
  input  logic [DEQ_W-1:0]               deq_accept,
  output logic [$clog2(DEPTH):0]         count,
  output logic                           full,
  output logic                           empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Handshake: an enqueue lane transfers when enq_valid[i] is high in a cycle
  // where get_data_req (registered credit) is high; a dequeue lane transfers
  // when deq_valid[i] and deq_accept[i] are both high and every lower lane
  // also transfers. Flush discards both sides of that cycle.

  logic [AW-1:0]                 wr_ptr, rd_ptr;
  logic [CW-1:0]                 count_q, count_next;
  logic                          req_q;
  logic [ENQ_W-1:0]              enq_take;
  logic [CW-1:0]                 n_enq, n_deq, n_skip;
  logic                          bypass;
  logic [ENQ_W-1:0]              wr_en;
  logic [ENQ_W-1:0][AW-1:0]      wr_addr;
  logic [DEQ_W-1:0][AW-1:0]      rd_addr;
  logic [DEQ_W-1:0][DATA_W-1:0]  ram_data;
  logic [DEQ_W-1:0][DATA_W-1:0]  byp_data;

  decode_queue_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ENQ_W  (ENQ_W),
    .DEQ_W  (DEQ_W),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (enq_data),
    .rd_addr (rd_addr),
    .rd_data (ram_data)
  );

  always_comb begin
    int slot;
    enq_take = enq_valid & {ENQ_W{req_q}};
    n_enq    = CW'(popcount(32'(enq_take)));
`ifdef DECODE_QUEUE_BYPASS_EN
    bypass   = req_q && (count_q == '0);
`else
    bypass   = 1'b0;
`endif

    // Compacted enqueue lanes, oldest first, as seen by the bypass path.
    slot = 0;
    for (int k = 0; k < DEQ_W; k++) byp_data[k] = '0;
    for (int i = 0; i < ENQ_W; i++) begin
      for (int k = 0; k < DEQ_W; k++) begin
        if (enq_take[i] && (slot == k)) byp_data[k] = enq_data[i];
      end
      slot += int'(enq_take[i]);
    end

    for (int i = 0; i < DEQ_W; i++) begin
      rd_addr[i]   = rd_ptr + AW'(i);
      deq_valid[i] = bypass ? (n_enq > CW'(i)) : (count_q > CW'(i));
      deq_data[i]  = bypass ? byp_data[i] : ram_data[i];
    end

    n_deq  = CW'(lead_ones(32'(deq_accept & deq_valid), DEQ_W));
    // Entries taken straight off the bypass never land in storage.
    n_skip = bypass ? n_deq : '0;

    slot = 0;
    for (int i = 0; i < ENQ_W; i++) begin
      wr_en[i]   = enq_take[i] && !flush && (slot >= int'(n_skip));
      wr_addr[i] = wr_ptr + AW'(slot) - AW'(n_skip);
      slot += int'(enq_take[i]);
    end

    count_next = count_q + n_enq - n_deq;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      req_q   <= 1'b1;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      req_q   <= 1'b1;
    end else begin
      wr_ptr  <= wr_ptr + AW'(n_enq - n_skip);
      rd_ptr  <= rd_ptr + (bypass ? '0 : AW'(n_deq));
      count_q <= count_next;
      req_q   <= (count_next <= CW'(DEPTH - ENQ_W));
    end
  end

  assign count        = count_q;
  assign get_data_req = req_q;
  assign full         = (count_q == CW'(DEPTH));
  assign empty        = (count_q == '0);

endmodule
